// File: rtl/ula_pkg.sv
// Shared types and constants for the ULA datapath and its sequencing controller.
package ula_pkg;

  localparam int W = 4;

  typedef enum logic [2:0] {
    CMD_LOAD = 3'b000,
    CMD_ADD  = 3'b001,
    CMD_SUB  = 3'b010,
    CMD_AND  = 3'b011,
    CMD_OR   = 3'b100,
    CMD_MUL  = 3'b101,
    CMD_READ = 3'b110,
    CMD_CLR  = 3'b111
  } cmd_op_t;

  typedef enum logic [1:0] {
    ALU_SUM = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_RESP = 2'b11
  } ctrl_state_t;

  // Commands that do not use the ALU fall through to SUM; their result is not selected.
  function automatic alu_op_t alu_op_of(input cmd_op_t op);
    case (op)
      CMD_SUB: return ALU_SUB;
      CMD_AND: return ALU_AND;
      CMD_OR:  return ALU_OR;
      default: return ALU_SUM;
    endcase
  endfunction

endpackage

// File: rtl/ula.sv
// Combinational 4-bit ALU: sum, subtract, and, or. Results wrap modulo 2^W.
module ULA
  import ula_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] s
);

  always_comb begin
    s = '0;
    case (alu_op_t'(op))
      ALU_SUM: s = a + b;
      ALU_SUB: s = a - b;
      ALU_AND: s = a & b;
      ALU_OR:  s = a | b;
      default: s = '0;
    endcase
  end

endmodule

// File: rtl/ula_ctrl.sv
// Accumulator front end for ULA: command/response handshakes, single-cycle ops,
// and a 4-cycle shift-and-add multiply that reuses the one shared ALU adder.
module ula_ctrl
  import ula_pkg::*;
#(
  parameter int MUL_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_zero,
  output logic       busy
);

  ctrl_state_t   state_reg, state_next;
  cmd_op_t       op_reg, op_next;
  logic [W-1:0]  acc_reg, acc_next;
  logic          zero_reg, zero_next;
  logic [W-1:0]  data_reg, data_next;
  logic [W-1:0]  prod_reg, prod_next;
  logic [W-1:0]  mcand_reg, mcand_next;
  logic [W-1:0]  mplier_reg, mplier_next;
  logic [1:0]    cnt_reg, cnt_next;

  logic [W-1:0]  alu_a, alu_b, alu_s;
  alu_op_t       alu_op;

  ULA u_ula (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .s  (alu_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      op_reg     <= CMD_LOAD;
      acc_reg    <= '0;
      zero_reg   <= 1'b1;
      data_reg   <= '0;
      prod_reg   <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      acc_reg    <= acc_next;
      zero_reg   <= zero_next;
      data_reg   <= data_next;
      prod_reg   <= prod_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    acc_next    = acc_reg;
    zero_next   = zero_reg;
    data_next   = data_reg;
    prod_next   = prod_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;
    alu_a       = acc_reg;
    alu_b       = data_reg;
    alu_op      = alu_op_of(op_reg);

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_next   = cmd_op_t'(cmd_op);
          data_next = cmd_data;
          if (cmd_op_t'(cmd_op) == CMD_MUL && MUL_EN != 0) begin
            prod_next   = '0;
            mcand_next  = acc_reg;
            mplier_next = cmd_data;
            cnt_next    = 2'd0;
            state_next  = ST_MUL;
          end else begin
            state_next = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        // MUL only lands here when disabled, and then acts as a no-op like READ.
        case (op_reg)
          CMD_LOAD:                          acc_next = data_reg;
          CMD_ADD, CMD_SUB, CMD_AND, CMD_OR: acc_next = alu_s;
          CMD_CLR:                           acc_next = '0;
          default:                           acc_next = acc_reg;
        endcase
        zero_next  = (acc_next == '0);
        state_next = ST_RESP;
      end

      ST_MUL: begin
        alu_a  = prod_reg;
        alu_b  = mcand_reg << cnt_reg;
        alu_op = ALU_SUM;
        if (mplier_reg[cnt_reg])
          prod_next = alu_s;
        if (cnt_reg == 2'd3) begin
          acc_next   = prod_next;
          zero_next  = (prod_next == '0);
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end

      ST_RESP: begin
        if (res_ready)
          state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_reg == ST_IDLE) && !rst;
  assign res_valid = (state_reg == ST_RESP);
  assign res_data  = acc_reg;
  assign res_zero  = zero_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ula_ctrl.sv
// Bench for ula_ctrl: directed commands, expected responses queued at accept time
// and checked by an independent monitor on each response handshake.
module tb_ula_ctrl;
  import ula_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cmd_valid, cmd_ready, res_valid, res_ready, res_zero, busy;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data, res_data;

  logic       cmd_valid0, cmd_ready0, res_valid0, res_ready0, res_zero0, busy0;
  logic [2:0] cmd_op0;
  logic [3:0] cmd_data0, res_data0;

  ula_ctrl #(.MUL_EN(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
    .busy(busy)
  );

  ula_ctrl #(.MUL_EN(0)) dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_op(cmd_op0), .cmd_data(cmd_data0),
    .res_valid(res_valid0), .res_ready(res_ready0), .res_data(res_data0), .res_zero(res_zero0),
    .busy(busy0)
  );

  typedef struct packed {
    logic [3:0] d;
    logic       z;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] d);
    exp_t e;
    e.d = d;
    e.z = (d == 4'd0);
    exp_q.push_back(e);
  endtask

  // Monitor: every response transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_data", int'(res_data), int'(mon_e.d));
        chk("res_zero", int'(res_zero), int'(mon_e.z));
        $display("response data=%0d zero=%0d", res_data, res_zero);
      end
    end
  end

  // Issue one command with res_ready high; checks latency and cmd_ready while busy.
  task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [3:0] exp,
                      input int lat, input string nm);
    bit ok;
    int got;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk({nm, "_accept_timeout"}, 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    push_exp(exp);
    $display("cmd %s op=%0d data=%0d expect=%0d", nm, op, d, exp);
    got = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk({nm, "_cmd_ready_low"}, int'(cmd_ready), 0);
      if (res_valid) begin got = k; break; end
    end
    chk({nm, "_latency"}, got, lat);
    @(posedge clk); #1;
  endtask

  // Same for the MUL-disabled instance, checked directly.
  task automatic send0(input logic [2:0] op, input logic [3:0] d, input logic [3:0] exp,
                       input int lat, input string nm);
    bit ok;
    int got;
    cmd_valid0 = 1'b1; cmd_op0 = op; cmd_data0 = d;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk({nm, "_accept_timeout"}, 0, 1);
      cmd_valid0 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid0 = 1'b0;
    got = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (res_valid0) begin got = k; break; end
    end
    chk({nm, "_latency"}, got, lat);
    chk({nm, "_data"}, int'(res_data0), int'(exp));
    $display("cmd0 %s op=%0d data=%0d got=%0d expect=%0d", nm, op, d, res_data0, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = CMD_LOAD; cmd_data = 4'd9; res_ready = 1'b1;
    cmd_valid0 = 1'b0; cmd_op0 = CMD_LOAD; cmd_data0 = 4'd0; res_ready0 = 1'b1;

    // Reset: command presented meanwhile must be dropped.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data",  int'(res_data), 0);
    chk("rst_res_zero",  int'(res_zero), 1);
    chk("rst_busy",      int'(busy), 0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;

    send(CMD_LOAD, 4'd5, 4'd5,  2, "load5");
    send(CMD_ADD,  4'd3, 4'd8,  2, "add3");
    send(CMD_SUB,  4'd9, 4'd15, 2, "sub9");
    send(CMD_AND,  4'd6, 4'd6,  2, "and6");
    send(CMD_OR,   4'd9, 4'd15, 2, "or9");
    send(CMD_CLR,  4'd5, 4'd0,  2, "clr");

    send(CMD_LOAD, 4'd7,  4'd7,  2, "load7");
    send(CMD_MUL,  4'd3,  4'd5,  5, "mul3");
    send(CMD_LOAD, 4'd15, 4'd15, 2, "load15");
    send(CMD_MUL,  4'd15, 4'd1,  5, "mul15");
    send(CMD_MUL,  4'd0,  4'd0,  5, "mul0");

    // Backpressure: ADD 4 onto 2, response held 4 cycles, LOAD 11 waiting behind it.
    send(CMD_LOAD, 4'd2, 4'd2, 2, "load2");
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = CMD_ADD; cmd_data = 4'd4;
    @(negedge clk);
    chk("bp_accept_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    push_exp(4'd6);
    $display("cmd bp_add op=%0d data=4 expect=6", CMD_ADD);
    cmd_op = CMD_LOAD; cmd_data = 4'd11;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1'b1; break; end
    end
    chk("bp_res_valid_seen", int'(ok), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(res_valid), 1);
      chk("bp_hold_data",  int'(res_data), 6);
      chk("bp_hold_cmd_ready", int'(cmd_ready), 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_cycle_cmd_ready", int'(cmd_ready), 0);
    @(negedge clk);
    chk("bp_after_handshake_cmd_ready", int'(cmd_ready), 1);
    chk("bp_after_handshake_busy", int'(busy), 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    push_exp(4'd11);
    $display("cmd bp_load op=%0d data=11 expect=11", CMD_LOAD);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1'b1; break; end
    end
    chk("bp_load_response_seen", int'(ok), 1);
    @(posedge clk); #1;

    // Reset during MUL cycle i=2: no response, accumulator cleared.
    send(CMD_LOAD, 4'd3, 4'd3, 2, "load3");
    cmd_valid = 1'b1; cmd_op = CMD_MUL; cmd_data = 4'd5;
    @(negedge clk);
    chk("mulrst_accept_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("mulrst_busy_i2", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset asserted during MUL i=2");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("mulrst_no_response", int'(res_valid), 0);
    end
    @(posedge clk); #1;
    send(CMD_READ, 4'd9, 4'd0, 2, "read_after_rst");

    // MUL disabled: MUL behaves as a single-cycle no-op.
    send0(CMD_LOAD, 4'd7, 4'd7, 2, "nomul_load7");
    send0(CMD_MUL,  4'd3, 4'd7, 2, "nomul_mul3");

    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
